// File: rtl/debounce_poly_eval.sv
// Operator front end: debounced push-button press strobe plus a combinational
// cubic polynomial evaluator (Horner form, all arithmetic mod 2**WIDTH).
module debounce_poly_eval #(
   parameter int WIDTH           = 16,
   parameter int DEBOUNCE_CYCLES = 1000000,
   parameter int CNT_W           = 20
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             btn,
   output logic             enable,
   input  logic [WIDTH-1:0] a0,
   input  logic [WIDTH-1:0] a1,
   input  logic [WIDTH-1:0] a2,
   input  logic [WIDTH-1:0] a3,
   input  logic [WIDTH-1:0] x,
   output logic [WIDTH-1:0] value
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

   logic             sync1_r;
   logic             sync2_r;
   logic             db_state_r;
   logic             enable_r;
   logic [CNT_W-1:0] cnt_r;
   logic [WIDTH-1:0] value_s;

   // One Horner stage; the product and sum are deliberately truncated to WIDTH.
   function automatic logic [WIDTH-1:0] horner_step(
      input logic [WIDTH-1:0] acc,
      input logic [WIDTH-1:0] pt,
      input logic [WIDTH-1:0] coef
   );
      logic [WIDTH-1:0] prod;
      prod = acc * pt;
      return prod + coef;
   endfunction

   // Synchroniser, debounce counter and press strobe.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sync1_r    <= 1'b0;
         sync2_r    <= 1'b0;
         db_state_r <= 1'b0;
         cnt_r      <= CNT_ZERO;
         enable_r   <= 1'b0;
      end else begin
         sync1_r  <= btn;
         sync2_r  <= sync1_r;
         enable_r <= 1'b0;
         if (sync2_r == db_state_r) begin
            cnt_r <= CNT_ZERO;
         end else if (cnt_r == CNT_LAST) begin
            // sync2 differs from db_state here, so sync2=1 means a 0->1 acceptance
            db_state_r <= sync2_r;
            cnt_r      <= CNT_ZERO;
            enable_r   <= sync2_r;
         end else begin
            cnt_r <= cnt_r + CNT_ONE;
         end
      end
   end

   // Combinational cubic evaluation.
   always_comb begin
      value_s = horner_step(horner_step(horner_step(a3, x, a2), x, a1), x, a0);
   end

   assign enable = enable_r;
   assign value  = value_s;

endmodule

// File: tb/tb_debounce_poly_eval.sv
// Directed bench for debounce_poly_eval: per-cycle enable expectations and
// polynomial results go through a scoreboard queue and are checked on pop.
module tb_debounce_poly_eval;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        btn;
   logic        enable;
   logic [15:0] a0, a1, a2, a3, x;
   logic [15:0] value;

   logic        en_q[$];
   logic [15:0] val_q[$];
   int          vectors = 0;
   int          miscompares = 0;

   debounce_poly_eval #(.WIDTH(16), .DEBOUNCE_CYCLES(4), .CNT_W(3)) dut (
      .clk(clk), .rst_n(rst_n), .btn(btn), .enable(enable),
      .a0(a0), .a1(a1), .a2(a2), .a3(a3), .x(x), .value(value)
   );

   always #5 clk = ~clk;

   task automatic step(input logic b, input logic r, input logic exp_en, input string tag);
      logic want;
      btn   = b;
      rst_n = r;
      en_q.push_back(exp_en);
      @(posedge clk);
      #1;
      want = en_q.pop_front();
      vectors++;
      assert (enable === want) else begin
         miscompares++;
         $error("FAIL %s: enable observed %b expected %b at %0t", tag, enable, want, $time);
      end
   endtask

   task automatic run(input logic b, input int n, input int pulse_at, input string tag);
      for (int i = 0; i < n; i++) begin
         step(b, 1'b1, (i == pulse_at) ? 1'b1 : 1'b0, tag);
      end
   endtask

   task automatic poly(input logic [15:0] c0, input logic [15:0] c1, input logic [15:0] c2,
                       input logic [15:0] c3, input logic [15:0] xv, input string tag);
      logic [63:0] xx;
      logic [63:0] e;
      logic [15:0] want;
      xx = {48'd0, xv};
      e  = {48'd0, c0} + {48'd0, c1} * xx + {48'd0, c2} * xx * xx + {48'd0, c3} * xx * xx * xx;
      val_q.push_back(e[15:0]);
      a0 = c0; a1 = c1; a2 = c2; a3 = c3; x = xv;
      #1;
      want = val_q.pop_front();
      vectors++;
      assert (value === want) else begin
         miscompares++;
         $error("FAIL %s: value observed %0d expected %0d (x=%0d)", tag, value, want, xv);
      end
   endtask

   initial begin
      btn = 1'b0; rst_n = 1'b0;
      a0 = 16'd0; a1 = 16'd0; a2 = 16'd0; a3 = 16'd0; x = 16'd0;

      for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, "reset");
      run(1'b0, 3, -1, "idle");

      run(1'b1, 20, 5, "clean_press");
      run(1'b0, 10, -1, "clean_release");

      run(1'b1, 3, -1, "bounce_hi1");
      run(1'b0, 2, -1, "bounce_lo");
      run(1'b1, 3, -1, "bounce_hi2");
      run(1'b0, 4, -1, "bounce_settle");
      run(1'b1, 10, 5, "post_bounce_press");
      run(1'b0, 10, -1, "post_bounce_release");

      run(1'b1, 8, 5, "press_a");
      run(1'b0, 10, -1, "release_a");
      run(1'b1, 8, 5, "press_b");
      run(1'b0, 10, -1, "release_b");

      run(1'b1, 4, -1, "pre_reset_count");
      step(1'b1, 1'b0, 1'b0, "mid_count_reset");
      run(1'b1, 10, 5, "post_reset_press");
      run(1'b0, 10, -1, "post_reset_release");

      poly(16'd1, 16'd2, 16'd3, 16'd4, 16'd2, "poly_1234_x2");
      poly(16'd1, 16'd2, 16'd3, 16'd4, 16'd0, "poly_x0");
      poly(16'd0, 16'd0, 16'd0, 16'd1, 16'd41, "poly_cube_wrap");
      poly(16'd1, 16'd2, 16'd3, 16'd4, 16'd3, "poly_async_x3");
      poly(16'd7, 16'd0, 16'd0, 16'd0, 16'd1234, "poly_const");
      poly(16'd0, 16'd5, 16'd0, 16'd0, 16'd300, "poly_linear");
      poly(16'd0, 16'd0, 16'd9, 16'd0, 16'd77, "poly_quad");
      for (int i = 0; i < 8; i++) begin
         poly(16'd0, 16'd0, 16'd0, 16'd0, 16'($urandom), "poly_zero");
      end
      for (int i = 0; i < 6; i++) begin
         poly(16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom), "poly_rand");
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
